axis_uart_rx_ovs: RTL

Parametrised oversampling UART receiver with AXI-Stream output, the next-generation RX path of the axis_uart subsystem. It supports runtime baud divider, parity mode and 1/2 stop bits, with a compile-time data width. Errors travel with each word on tuser, and overrun is flagged. It sits between the board rx pin and the RX FIFO of the UART register block.

---
 rtl/axis_uart_rx_ovs.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/axis_uart_rx_ovs.sv
// axis_uart_rx_ovs -- oversampling UART receiver with an AXI-Stream output.
//
// Receives serial characters from rx_i. Each word is presented on m_axis_*
// with {frame_err, parity_err} on tuser. A word that arrives while the
// output register is still full and not being accepted is dropped, and
// overrun_o pulses for one cycle.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   rx_i                  asynchronous serial line, idle high
//   clk_divider_i         clk_i cycles per oversample tick (0 behaves as 1)
//   parity_odd_i          odd parity (has priority over parity_even_i)
//   parity_even_i         even parity
//   stop2_i               1: two stop bits, 0: one stop bit
//   m_axis_tdata/tuser/tvalid/tready   AXI-Stream master output
//   overrun_o             one-cycle pulse when a word is dropped
//   busy_o                frame in progress (state not IDLE)
//
// Build option: define UART_RX_MAJORITY_EN to decide every bit by a 2-of-3
// vote of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
// Without it, a single sample at tick OVERSAMPLE/2 is used.
module axis_uart_rx_ovs #(
  parameter int DATA_WIDTH    = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int DIVIDER_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rx_i,
  input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
  input  logic                     parity_odd_i,
  input  logic                     parity_even_i,
  input  logic                     stop2_i,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [1:0]               m_axis_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     overrun_o,
  output logic                     busy_o
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_WIDTH + 1);
  // os_cnt_q holds the number of ticks already seen in the current bit, so
  // "tick N" of a bit is the tick seen while os_cnt_q == N-1.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [OSW-1:0] DEC_IDX = OSW'(OVERSAMPLE/2);
`else
  localparam logic [OSW-1:0] DEC_IDX = OSW'(OVERSAMPLE/2 - 1);
`endif
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_e;

  state_e                   state_q, state_d;
  logic                     rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DIVIDER_WIDTH-1:0] div_q, div_cnt_q;
  logic [OSW-1:0]           os_cnt_q;
  logic [BCW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                     stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0]    sh_q, sh_d;
  logic                     par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic                     par_odd_q, par_even_q, stop2_q;
  logic                     fall, tick, samp, bit_val, par_exp, push;

  assign fall    = rx_prev_q & ~rx_s2_q;
  assign tick    = (state_q != S_IDLE) && (div_cnt_q == div_q - DIVIDER_WIDTH'(1));
  assign samp    = tick && (os_cnt_q == DEC_IDX);
  assign par_exp = par_odd_q ? ~^sh_q : ^sh_q;
  assign busy_o  = (state_q != S_IDLE);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q;
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s2_q) | (vote_q[1] & rx_s2_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) vote_q <= 2'b11;
    else if (tick && os_cnt_q == DEC_IDX - OSW'(2)) vote_q[0] <= rx_s2_q;
    else if (tick && os_cnt_q == DEC_IDX - OSW'(1)) vote_q[1] <= rx_s2_q;
  end
`else
  assign bit_val = rx_s2_q;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    sh_d       = sh_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: if (fall) begin
        state_d    = S_START;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        par_err_d  = 1'b0;
        frm_err_d  = 1'b0;
      end
      S_START: if (samp) state_d = bit_val ? S_IDLE : S_DATA;  // high at mid-start = glitch
      S_DATA: if (samp) begin
        sh_d = {bit_val, sh_q[DATA_WIDTH-1:1]};                 // LSB first
        if (bit_cnt_q == BIT_LAST)
          state_d = (par_odd_q | par_even_q) ? S_PARITY : S_STOP;
        else
          bit_cnt_d = bit_cnt_q + BCW'(1);
      end
      S_PARITY: if (samp) begin
        par_err_d = (bit_val != par_exp);
        state_d   = S_STOP;
      end
      S_STOP: if (samp) begin
        if (!bit_val) frm_err_d = 1'b1;
        if (stop2_q && !stop_cnt_q) begin
          stop_cnt_d = 1'b1;
        end else begin
          push    = 1'b1;
          // a low stop bit may be the start of a break: wait for the line to recover
          state_d = frm_err_d ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: if (rx_s2_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      div_q      <= DIVIDER_WIDTH'(1);
      div_cnt_q  <= '0;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      sh_q       <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      par_odd_q  <= 1'b0;
      par_even_q <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      sh_q       <= sh_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      // counters stay at 0 in IDLE so bit timing is anchored to the start edge
      if (state_q == S_IDLE) begin
        div_cnt_q <= '0;
        os_cnt_q  <= '0;
      end else if (tick) begin
        div_cnt_q <= '0;
        os_cnt_q  <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OSW'(1);
      end else begin
        div_cnt_q <= div_cnt_q + DIVIDER_WIDTH'(1);
      end
      // frame configuration is frozen at the start edge
      if (state_q == S_IDLE && fall) begin
        div_q      <= (clk_divider_i == '0) ? DIVIDER_WIDTH'(1) : clk_divider_i;
        par_odd_q  <= parity_odd_i;
        par_even_q <= parity_even_i;
        stop2_q    <= stop2_i;
      end
    end
  end

  // Output register: a push wins over a pending word only if that word leaves this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (push) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tdata  <= sh_q;
          m_axis_tuser  <= {frm_err_d, par_err_q};
          m_axis_tvalid <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
